// File: rtl/mod_exp_seq_if.sv
// Handshake and operand bus between the exponentiation sequencer and the
// modular multiplier. The sequencer is the master, the multiplier is the slave.
interface mod_exp_seq_if #(
  parameter int NBITS = 2048
);
  logic             mm_enable_p;
  logic [NBITS-1:0] mm_a;
  logic [NBITS-1:0] mm_b;
  logic [NBITS-1:0] mm_m;
  logic [NBITS-1:0] mm_y;
  logic             mm_done_p;

  modport master (
    output mm_enable_p, mm_a, mm_b, mm_m,
    input  mm_y, mm_done_p
  );

  modport slave (
    input  mm_enable_p, mm_a, mm_b, mm_m,
    output mm_y, mm_done_p
  );
endinterface

// File: rtl/mod_exp_seq.sv
// Left-to-right binary modular exponentiation sequencer: scans the exponent
// MSB first and drives square/multiply jobs into one external multiplier.
module mod_exp_seq #(
  parameter int NBITS = 2048,
  parameter int EBITS = 2048
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic [NBITS-1:0] base,
  input  logic [EBITS-1:0] exp,
  input  logic [NBITS-1:0] m,
  output logic [NBITS-1:0] y,
  output logic             busy,
  output logic             err,
  output logic             done_irq_p,
  mod_exp_seq_if.master    mm
);
  localparam int CW = $clog2(EBITS + 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SCAN     = 3'd1;
  localparam logic [2:0] SQR_ISS  = 3'd2;
  localparam logic [2:0] SQR_WAIT = 3'd3;
  localparam logic [2:0] MUL_ISS  = 3'd4;
  localparam logic [2:0] MUL_WAIT = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [NBITS-1:0] r_q, r_d, b_q, b_d, m_q, m_d;
  logic [EBITS-1:0] e_q, e_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_dec;
  logic [NBITS-1:0] y_q, y_d;
  logic             busy_q, busy_d, err_q, err_d, done_q, done_d;
  logic             mm_en_q, mm_en_d;
  logic [NBITS-1:0] mm_a_q, mm_a_d, mm_b_q, mm_b_d, mm_m_q, mm_m_d;
  logic             msb;

  assign msb     = e_q[EBITS-1];
  assign cnt_dec = cnt_q - CW'(1);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    b_d     = b_q;
    m_d     = m_q;
    e_d     = e_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    err_d   = err_q;
    mm_en_d = 1'b0;
    mm_a_d  = mm_a_q;
    mm_b_d  = mm_b_q;
    mm_m_d  = mm_m_q;
    case (state_q)
      IDLE: begin
        if (start_p) begin
          b_d   = base;
          m_d   = m;
          e_d   = exp;
          cnt_d = CW'(EBITS);
          r_d   = NBITS'(1);
          y_d   = '0;
          // base >= m would let operands escape the residue range
          if (m < NBITS'(2) || base >= m) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        e_d   = e_q << 1;
        cnt_d = cnt_dec;
        if (msb) r_d = b_q;
        if (cnt_dec == '0) state_d = DONE;
        else if (msb)      state_d = SQR_ISS;
      end
      SQR_ISS: begin
        mm_a_d  = r_q;
        mm_b_d  = r_q;
        mm_m_d  = m_q;
        mm_en_d = 1'b1;
        state_d = SQR_WAIT;
      end
      SQR_WAIT: begin
        if (mm.mm_done_p) begin
          r_d   = mm.mm_y;
          e_d   = e_q << 1;
          cnt_d = cnt_dec;
          if (msb)                 state_d = MUL_ISS;
          else if (cnt_dec != '0)  state_d = SQR_ISS;
          else                     state_d = DONE;
        end
      end
      MUL_ISS: begin
        mm_a_d  = r_q;
        mm_b_d  = b_q;
        mm_m_d  = m_q;
        mm_en_d = 1'b1;
        state_d = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (mm.mm_done_p) begin
          r_d     = mm.mm_y;
          state_d = (cnt_q != '0) ? SQR_ISS : DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The error path already forced y to zero in IDLE
    if (state_d == DONE && state_q != IDLE) y_d = r_d;
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      mm_en_q <= 1'b0;
      mm_a_q  <= '0;
      mm_b_q  <= '0;
      mm_m_q  <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      done_q  <= done_d;
      mm_en_q <= mm_en_d;
      mm_a_q  <= mm_a_d;
      mm_b_q  <= mm_b_d;
      mm_m_q  <= mm_m_d;
    end
  end

  // Working registers are always loaded on an accepted start
  always_ff @(posedge clk) begin
    r_q   <= r_d;
    b_q   <= b_d;
    m_q   <= m_d;
    e_q   <= e_d;
    cnt_q <= cnt_d;
  end

  assign y              = y_q;
  assign busy           = busy_q;
  assign err            = err_q;
  assign done_irq_p     = done_q;
  assign mm.mm_enable_p = mm_en_q;
  assign mm.mm_a        = mm_a_q;
  assign mm.mm_b        = mm_b_q;
  assign mm.mm_m        = mm_m_q;
endmodule
